// File: rtl/recolector_sumas_pkg.sv
// recolector_sumas_pkg: shared widths, table depth and readout FSM encoding
package recolector_sumas_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_IDX_W  = 4;
    localparam int DEF_ACC_W  = 8;
    localparam int DEF_CNT_W  = 8;
    localparam int DEPTH      = 2 ** DEF_IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/recolector_sumas_if.sv
// recolector_sumas_if: sample input bus and table readout stream
interface recolector_sumas_if
    import recolector_sumas_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int ACC_W  = DEF_ACC_W
);

    logic              in_valid;
    logic [DATA_W-1:0] sum_in;
    logic [IDX_W-1:0]  idx_in;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [IDX_W-1:0]  dump_idx;
    logic [ACC_W-1:0]  dump_data;
    logic              dump_busy;
    logic              dump_done;

    modport master (
        output in_valid, sum_in, idx_in, dump_start, dump_ready,
        input  dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  in_valid, sum_in, idx_in, dump_start, dump_ready,
        output dump_valid, dump_idx, dump_data, dump_busy, dump_done
    );

endinterface

// File: rtl/recolector_sumas_sumador_sat.sv
// sumador_sat: accumulator plus zero-extended sample, clamped at all-ones
module sumador_sat
    import recolector_sumas_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_sum,
    output logic [ACC_W-1:0]  o_res,
    output logic              o_ovf
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, i_acc} + (ACC_W + 1)'(i_sum);
    assign o_ovf  = w_full[ACC_W];
    assign o_res  = o_ovf ? '1 : w_full[ACC_W-1:0];

endmodule

// File: rtl/recolector_sumas.sv
// recolector_sumas: per-index saturating accumulator table with streamed readout
module recolector_sumas
    import recolector_sumas_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr,
    recolector_sumas_if.slave bus,
    output logic             sat_flag,
    output logic [CNT_W-1:0] count
);

    localparam int TAB_DEPTH = 2 ** IDX_W;

    logic [ACC_W-1:0] r_tab [TAB_DEPTH];
    state_t           r_state, w_state_n;
    logic [IDX_W-1:0] r_ptr, w_ptr_n, w_load_idx;
    logic [ACC_W-1:0] r_data, w_data_n, w_wr_res, w_load_data;
    logic             r_done, w_done_n;
    logic             r_sat;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ovf, w_hs, w_last;

    // One adder serves both the table write and the dump-load bypass
    sumador_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_sumador_sat (
        .i_acc (r_tab[bus.idx_in]),
        .i_sum (bus.sum_in),
        .o_res (w_wr_res),
        .o_ovf (w_ovf)
    );

    // Entry about to be loaded: 0 when starting, else the next pointer
    assign w_load_idx  = (r_state == IDLE) ? '0 : r_ptr + 1'b1;
    assign w_load_data = (bus.in_valid && bus.idx_in == w_load_idx) ? w_wr_res : r_tab[w_load_idx];
    assign w_hs        = (r_state == SEND) && bus.dump_ready;
    assign w_last      = &r_ptr;

    // Table: clear wins over a same-cycle sample
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            for (int i = 0; i < TAB_DEPTH; i++) r_tab[i] <= '0;
        else if (clr)
            for (int i = 0; i < TAB_DEPTH; i++) r_tab[i] <= '0;
        else if (bus.in_valid)
            r_tab[bus.idx_in] <= w_wr_res;
    end

    // Sticky saturation flag and saturating sample counter
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (clr) begin
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (bus.in_valid) begin
            r_sat <= r_sat | w_ovf;
            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        end
    end

    // Readout FSM state, pointer, held word and done pulse
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_data  <= w_data_n;
            r_done  <= w_done_n;
        end
    end

    // Next state: clear aborts, handshake advances or finishes the stream
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_data_n  = r_data;
        w_done_n  = 1'b0;
        if (clr) begin
            w_state_n = IDLE;
            w_ptr_n   = '0;
            w_data_n  = '0;
        end else if (r_state == IDLE && bus.dump_start) begin
            w_state_n = SEND;
            w_ptr_n   = '0;
            w_data_n  = w_load_data;
        end else if (w_hs && w_last) begin
            w_state_n = IDLE;
            w_done_n  = 1'b1;
        end else if (w_hs) begin
            w_ptr_n   = w_load_idx;
            w_data_n  = w_load_data;
        end
    end

    assign bus.dump_valid = (r_state == SEND);
    assign bus.dump_busy  = (r_state == SEND);
    assign bus.dump_idx   = r_ptr;
    assign bus.dump_data  = r_data;
    assign bus.dump_done  = r_done;
    assign sat_flag       = r_sat;
    assign count          = r_cnt;

endmodule

// File: tb/tb_recolector_sumas.sv
// tb_recolector_sumas: directed scenario tests for the accumulator table and readout
module tb_recolector_sumas;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       clr;
    logic       sat_flag;
    logic [7:0] count;

    int errors = 0;
    int checks = 0;

    logic [3:0] word_idx [16];
    logic [7:0] word_data [16];
    int n_words, n_done, first_cyc, last_cyc, done_cyc;
    logic busy_at_done;

    recolector_sumas_if bus ();

    recolector_sumas dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .clr      (clr),
        .bus      (bus),
        .sat_flag (sat_flag),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
    endtask

    task automatic collect();
        n_words = 0; n_done = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; busy_at_done = 1'b1;
        bus.dump_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.dump_valid) begin
                if (n_words < 16) begin
                    word_idx[n_words]  = bus.dump_idx;
                    word_data[n_words] = bus.dump_data;
                end
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                n_words++;
            end
            if (bus.dump_done) begin
                n_done++;
                done_cyc = c;
                busy_at_done = bus.dump_busy;
            end
            tick();
        end
        bus.dump_ready = 1'b0;
    endtask

    task automatic clear_table();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.dump_valid, bus.dump_busy, bus.dump_done, sat_flag} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.dump_valid, bus.dump_busy, bus.dump_done, sat_flag});
        end
        checks++;
        if (count !== 8'd0 || bus.dump_data !== 8'd0 || bus.dump_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_values got count=%0d data=%0d idx=%0d exp=0", count, bus.dump_data, bus.dump_idx);
        end
        reset_L = 1'b1;
        tick();
    endtask

    task automatic test_accumulate();
        bus.in_valid = 1'b1; bus.idx_in = 4'd3; bus.sum_in = 4'd5;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 8'd3) begin errors++; $display("FAIL acc_count got=%0d exp=3", count); end
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL acc_sat got=%b exp=0", sat_flag); end
        start_dump();
        collect();
        checks++;
        if (n_words !== 16 || last_cyc - first_cyc !== 15) begin
            errors++; $display("FAIL acc_words got=%0d span=%0d exp=16 span=15", n_words, last_cyc - first_cyc);
        end
        checks++;
        if (n_done !== 1 || done_cyc !== last_cyc + 1) begin
            errors++; $display("FAIL acc_done got=%0d at %0d exp=1 at %0d", n_done, done_cyc, last_cyc + 1);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (word_idx[i] !== 4'(i) || word_data[i] !== ((i == 3) ? 8'd15 : 8'd0)) begin
                errors++;
                $display("FAIL acc_word%0d got idx=%0d data=%0d exp idx=%0d data=%0d", i, word_idx[i], word_data[i], i, (i == 3) ? 15 : 0);
            end
        end
    endtask

    task automatic test_saturation();
        clear_table();
        checks++;
        if (count !== 8'd0) begin errors++; $display("FAIL sat_clr_count got=%0d exp=0", count); end
        bus.in_valid = 1'b1; bus.idx_in = 4'd7; bus.sum_in = 4'd15;
        repeat (17) tick();
        checks++;
        if (sat_flag !== 1'b0 || count !== 8'd17) begin
            errors++; $display("FAIL sat_exact got sat=%b count=%0d exp sat=0 count=17", sat_flag, count);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (sat_flag !== 1'b1 || count !== 8'd18) begin
            errors++; $display("FAIL sat_over got sat=%b count=%0d exp sat=1 count=18", sat_flag, count);
        end
        start_dump();
        collect();
        checks++;
        if (word_data[7] !== 8'd255 || word_data[6] !== 8'd0) begin
            errors++; $display("FAIL sat_entry got e7=%0d e6=%0d exp e7=255 e6=0", word_data[7], word_data[6]);
        end
    endtask

    task automatic test_backpressure();
        clear_table();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.idx_in = 4'(i); bus.sum_in = 4'(15 - i);
            tick();
        end
        bus.in_valid = 1'b0;
        start_dump();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.dump_valid !== 1'b1 || bus.dump_idx !== 4'd0 || bus.dump_data !== 8'd15) begin
                errors++;
                $display("FAIL bp_stall%0d got v=%b idx=%0d data=%0d exp v=1 idx=0 data=15", k, bus.dump_valid, bus.dump_idx, bus.dump_data);
            end
            bus.in_valid = (k == 1); bus.idx_in = 4'd0; bus.sum_in = 4'd1;
            tick();
            bus.in_valid = 1'b0;
        end
        collect();
        checks++;
        if (n_words !== 16 || last_cyc - first_cyc !== 15 || first_cyc !== 0) begin
            errors++; $display("FAIL bp_stream got n=%0d first=%0d last=%0d exp n=16 first=0 last=15", n_words, first_cyc, last_cyc);
        end
        checks++;
        if (n_done !== 1 || done_cyc !== 16 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL bp_done got n=%0d at %0d busy=%b exp n=1 at 16 busy=0", n_done, done_cyc, busy_at_done);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (word_idx[i] !== 4'(i) || word_data[i] !== 8'(15 - i)) begin
                errors++;
                $display("FAIL bp_word%0d got idx=%0d data=%0d exp idx=%0d data=%0d", i, word_idx[i], word_data[i], i, 15 - i);
            end
        end
    endtask

    task automatic test_bypass();
        clear_table();
        bus.in_valid = 1'b1; bus.idx_in = 4'd1; bus.sum_in = 4'd10;
        tick();
        bus.in_valid = 1'b0;
        start_dump();
        tick();
        checks++;
        if (bus.dump_valid !== 1'b1 || bus.dump_idx !== 4'd0) begin
            errors++; $display("FAIL byp_hold got v=%b idx=%0d exp v=1 idx=0", bus.dump_valid, bus.dump_idx);
        end
        bus.dump_ready = 1'b1; bus.in_valid = 1'b1; bus.idx_in = 4'd1; bus.sum_in = 4'd4;
        tick();
        bus.dump_ready = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.dump_idx !== 4'd1 || bus.dump_data !== 8'd14) begin
            errors++; $display("FAIL byp_word1 got idx=%0d data=%0d exp idx=1 data=14", bus.dump_idx, bus.dump_data);
        end
        collect();
        checks++;
        if (n_words !== 15 || n_done !== 1 || word_data[0] !== 8'd14) begin
            errors++; $display("FAIL byp_rest got n=%0d done=%0d d0=%0d exp n=15 done=1 d0=14", n_words, n_done, word_data[0]);
        end
    endtask

    task automatic test_clear_mid_dump();
        clear_table();
        bus.in_valid = 1'b1; bus.idx_in = 4'd2; bus.sum_in = 4'd9;
        tick();
        bus.in_valid = 1'b0;
        start_dump();
        bus.dump_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus.dump_idx !== 4'd5 || bus.dump_valid !== 1'b1) begin
            errors++; $display("FAIL clr_pre got idx=%0d v=%b exp idx=5 v=1", bus.dump_idx, bus.dump_valid);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0; bus.dump_ready = 1'b0;
        checks++;
        if ({bus.dump_valid, bus.dump_busy, bus.dump_done} !== 3'b000 || count !== 8'd0) begin
            errors++; $display("FAIL clr_abort got vbd=%b count=%0d exp vbd=000 count=0", {bus.dump_valid, bus.dump_busy, bus.dump_done}, count);
        end
        tick();
        checks++;
        if (bus.dump_done !== 1'b0) begin errors++; $display("FAIL clr_nodone got=%b exp=0", bus.dump_done); end
        start_dump();
        collect();
        checks++;
        if (n_words !== 16 || n_done !== 1 || word_data[2] !== 8'd0) begin
            errors++; $display("FAIL clr_redump got n=%0d done=%0d e2=%0d exp n=16 done=1 e2=0", n_words, n_done, word_data[2]);
        end
    endtask

    task automatic test_async_reset();
        clear_table();
        bus.in_valid = 1'b1; bus.idx_in = 4'd0; bus.sum_in = 4'd15;
        repeat (18) tick();
        bus.in_valid = 1'b0;
        start_dump();
        checks++;
        if (sat_flag !== 1'b1 || bus.dump_data !== 8'd255 || bus.dump_valid !== 1'b1) begin
            errors++; $display("FAIL ar_pre got sat=%b data=%0d v=%b exp sat=1 data=255 v=1", sat_flag, bus.dump_data, bus.dump_valid);
        end
        #2 reset_L = 1'b0;
        #1;
        checks++;
        if ({bus.dump_valid, bus.dump_busy, sat_flag} !== 3'b000 || bus.dump_data !== 8'd0 || count !== 8'd0) begin
            errors++;
            $display("FAIL ar_async got vbs=%b data=%0d count=%0d exp vbs=000 data=0 count=0", {bus.dump_valid, bus.dump_busy, sat_flag}, bus.dump_data, count);
        end
        #2 reset_L = 1'b1;
        tick();
        checks++;
        if (bus.dump_valid !== 1'b0 || bus.dump_done !== 1'b0) begin
            errors++; $display("FAIL ar_after got v=%b done=%b exp 0 0", bus.dump_valid, bus.dump_done);
        end
    endtask

    initial begin
        reset_L = 1'b0; clr = 1'b0;
        bus.in_valid = 1'b0; bus.sum_in = '0; bus.idx_in = '0;
        bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
        test_reset();
        test_accumulate();
        test_saturation();
        test_backpressure();
        test_bypass();
        test_clear_mid_dump();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/recolector_sumas.md
Name: recolector_sumas

Overview:
Downstream consumer of the pipelined 4-bit adder. Each valid cycle it takes the adder's delayed sum and index (sum30_dd_out / idx_dd_out) and accumulates the sum into a per-index table of 2**IDX_W saturating accumulators. On request, a readout FSM streams the whole table out over a valid/ready interface. The table gives the bench and later stages per-index totals without logging every sample.

Parameters:
DATA_W, 4, width of incoming sum (matches adder output)
IDX_W, 4, width of index; table depth = 2**IDX_W
ACC_W, 8, width of each accumulator entry (ACC_W > DATA_W)
CNT_W, 8, width of accepted-sample counter

Ports:
clk  in  1  single clock, rising edge
reset_L  in  1  asynchronous active-low reset
in_valid  in  1  sum_in/idx_in valid this cycle
sum_in  in  DATA_W  sum from adder stage
idx_in  in  IDX_W  index from adder stage
clr  in  1  synchronous clear of table, flags and counter
dump_start  in  1  request a full-table readout
dump_ready  in  1  consumer accepts dump word
dump_valid  out  1  dump_idx/dump_data valid
dump_idx  out  IDX_W  table index of current dump word
dump_data  out  ACC_W  accumulator value of current dump word
dump_busy  out  1  readout FSM not idle
dump_done  out  1  one-cycle pulse after final handshake
sat_flag  out  1  sticky; an accumulator has saturated
count  out  CNT_W  accepted samples, saturating

Behaviour:
- Reset (reset_L=0, async): all table entries 0. All outputs 0 immediately. FSM to IDLE, pointer 0. Reset mid-dump aborts it with no dump_done.
- Accumulate: at a posedge with in_valid=1 and clr=0: acc[idx_in] <= min(acc[idx_in] + zero-extended sum_in, 2**ACC_W-1).
  - The new value is visible from the next cycle.
  - sat_flag is set if the true sum exceeds the maximum; landing exactly on the maximum does not set it.
  - count increments by 1 and saturates at 2**CNT_W-1.
- Clear: clr=1 zeroes the table, sat_flag and count at the next edge.
  - clr beats in_valid: a same-cycle sample is dropped.
  - clr beats dump_start.
  - clr during a dump aborts it: FSM to IDLE, dump_valid=0, dump_busy=0, no dump_done.
- Readout FSM states:
  - IDLE: dump_valid=0, dump_busy=0. On dump_start (and clr=0), go to SEND at the next edge. In the same edge, load dump_idx=0 and dump_data=acc[0].
  - SEND: dump_valid=1, dump_busy=1. Without handshake (dump_ready=0), dump_idx and dump_data hold stable even if the table entry changes.
  - SEND, handshake on a non-final entry: dump_idx increments and dump_data loads the next entry with no bubble.
  - SEND, handshake on entry 2**IDX_W-1: go to IDLE, dump_valid=0, and pulse dump_done for one cycle.
  - dump_start while busy is ignored.
- Load bypass: when an entry is loaded into dump_data on the same edge that in_valid updates that entry, dump_data takes the updated (post-accumulate, saturated) value.
- Accumulation continues normally during a dump. Entries already sent are not re-sent.
- Latency:
  - Sample to table: 1 cycle.
  - dump_start to first dump_valid: 1 cycle.
  - Full dump: 2**IDX_W handshakes, minimum 16 cycles at the defaults.

Decomposition:
- Shared parameter/include file:
  - default widths DATA_W/IDX_W/ACC_W/CNT_W
  - FSM state encoding: IDLE=1'b0, SEND=1'b1
  - derived constant DEPTH = 2**IDX_W
- One natural sub-module, sumador_sat: combinational saturating add of ACC_W + DATA_W giving a saturated result and an overflow bit. It is used both for the table write and for the dump bypass value.
- The table, the counter and the FSM stay in recolector_sumas.

Test Plan:
- Accumulate: reset, then in_valid with idx_in=3, sum_in=5 for 3 cycles, then dump with dump_ready=1 -> entry 3 = 15, all other entries 0, count=3, sat_flag=0, dump_done pulses once after idx 15.
- Saturation: idx_in=7, sum_in=15 for 17 cycles -> acc[7]=255, sat_flag=0. One more sample -> acc[7]=255, sat_flag=1, count=18.
- Backpressure: dump_start, then dump_ready=0 for 4 cycles -> dump_idx=0 and dump_data stable, dump_valid=1. Then ready=1 -> 16 consecutive words idx 0..15, no bubbles, dump_busy falls with dump_done.
- Bypass: table entry 1 = 10. Hold dump_ready=0 on word 0, then handshake on the same cycle as in_valid with idx_in=1, sum_in=4 -> word 1 shows dump_data=14.
- Clear mid-dump: assert clr after 5 handshakes -> next cycle dump_valid=0, dump_busy=0, no dump_done, count=0. A new dump reads all zeros.
- Async reset mid-dump: drop reset_L between clock edges -> dump_valid, dump_data, count and sat_flag go to 0 before the next edge.
